// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequenced through one shared 4-bit ripple slice, LSB nibble
// first, one nibble per clock, with registered sum/carry-out/overflow on completion.

module nibble_add_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int k = 0; k < 4; k++) begin
            s[k]   = x[k] ^ y[k] ^ c[k];
            c[k+1] = (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
        end
    end

    // carry into the top bit is needed for signed overflow on the last nibble
    assign c3 = c[3];
    assign co = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [3:0]       nib_s;
    logic             nib_c3;
    logic             nib_co;

    nibble_add_slice u_slice (
        .x  (op_a[{idx, 2'b00} +: 4]),
        .y  (op_b[{idx, 2'b00} +: 4]),
        .ci (carry),
        .s  (nib_s),
        .c3 (nib_c3),
        .co (nib_co)
    );

    // Working result with the current nibble merged in, so the completion edge
    // can publish the full sum in the same cycle the last nibble is computed.
    always_comb begin
        work_nxt = work;
        work_nxt[{idx, 2'b00} +: 4] = nib_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    work  <= work_nxt;
                    carry <= nib_co;
                    idx   <= idx + IDXW'(1);
                    if (idx == LAST) begin
                        sum   <= work_nxt;
                        cout  <= nib_co;
                        ovf   <= nib_c3 ^ nib_co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and model-checked bench for nibble_serial_adder_ctrl at WIDTH=16 and WIDTH=4.

module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic on plain integers, independent of nibble sequencing.
    task automatic model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                         input logic msub, input logic mcin,
                         output logic [31:0] es, output logic ec, output logic eo);
        logic [63:0] mask, bb, t;
        mask = (64'd1 << w) - 64'd1;
        bb   = msub ? (~{32'd0, mb}) & mask : {32'd0, mb};
        t    = {32'd0, ma} + bb + (msub ? 64'd1 : {63'd0, mcin});
        es   = t[31:0] & mask[31:0];
        ec   = t[w];
        eo   = (ma[w-1] == bb[w-1]) && (es[w-1] != ma[w-1]);
    endtask

    // Called at a negedge; accepts on the next posedge and waits for done.
    task automatic op16(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                        input logic osub, input logic ocin,
                        input logic [15:0] es, input logic ec, input logic eo);
        logic [15:0] prev;
        int lat;
        prev  = sum;
        start = 1'b1; a = oa; b = ob; sub = osub; cin = ocin;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy"}, busy, 1'b1);
        chk({tag, ".held"}, sum, prev);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, 4);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ovf"}, ovf, eo);
        chk({tag, ".idle"}, busy, 1'b0);
    endtask

    task automatic op4(input logic [3:0] oa, input logic [3:0] ob, input logic osub,
                       input logic ocin);
        logic [31:0] es;
        logic ec, eo;
        int lat;
        model(4, {28'd0, oa}, {28'd0, ob}, osub, ocin, es, ec, eo);
        start4 = 1'b1; a4 = oa; b4 = ob; sub4 = osub; cin4 = ocin;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("w4.lat", lat, 1);
        chk("w4.res", {cout4, ovf4, sum4}, {ec, eo, es[3:0]});
    endtask

    initial begin
        int lat, pulses;
        logic [31:0] es;
        logic ec, eo;

        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.res", {cout, ovf, sum}, 18'h0);
        rst_n = 1'b1;
        @(negedge clk);

        op16("add_carry_ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_single", done, 1'b0);
        op16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        op16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        op16("add_cin", 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0);
        @(negedge clk);
        op16("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);
        op16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        // back-to-back: issued in the done cycle of the previous op
        op16("b2b", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
        @(negedge clk);

        // start while busy, plus operand changes mid-run
        start = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_ign.lat", lat, 4);
        chk("busy_ign.res", {cout, ovf, sum}, {2'b00, 16'h0002});
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("busy_ign.pulses", pulses, 0);
        chk("busy_ign.idle", busy, 1'b0);

        // reset during the second run cycle
        start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.done", done, 1'b0);
        chk("midrst.res", {cout, ovf, sum}, 18'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("midrst.quiet", pulses, 0);
        op16("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

        // model-checked random ops, issued back-to-back
        for (int i = 0; i < 200; i++) begin
            logic [15:0] ra, rb;
            logic rs, rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            model(16, {16'd0, ra}, {16'd0, rb}, rs, rc, es, ec, eo);
            op16("rand16", ra, rb, rs, rc, es[15:0], ec, eo);
        end
        @(negedge clk);

        // WIDTH=4: exhaustive operands, single-cycle run
        for (int i = 0; i < 512; i++) begin
            op4(4'(i), 4'(i >> 4), 1'(i >> 8), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
